// File: rtl/centroid_wr_engine.sv
// centroid_wr_engine: buffers updated centroid cachelines and issues them as addressed write requests.
// Optional debug counters are enabled by defining CENTROID_WR_DEBUG_EN.
`default_nettype none

module centroid_wr_engine #(
    parameter int FIFO_DEPTH = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_operator,
    input  logic [63:0]  centroid_base_addr,
    input  logic [31:0]  num_iteration,
    input  logic [511:0] updated_centroid,
    input  logic         updated_centroid_valid,
    input  logic         updated_centroid_last,
    output logic         wr_req_valid,
    input  logic         wr_req_ready,
    output logic [63:0]  wr_req_addr,
    output logic [511:0] wr_req_data,
    output logic         wr_req_last,
    output logic         iteration_done,
    output logic [31:0]  iteration_cnt,
    output logic         all_done,
    output logic         overflow
`ifdef CENTROID_WR_DEBUG_EN
    ,
    output logic [3:0][31:0] wr_debug_cnt
`endif
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nx;

    logic [512:0]       r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;

    logic [63:0]        r_base;
    logic [63:0]        r_offset;
    logic [31:0]        r_num_iter;
    logic [31:0]        r_iter_cnt;
    logic               r_iter_done;
    logic               r_all_done;
    logic               r_overflow;

    logic               w_in_write;
    logic               w_start;
    logic               w_full;
    logic               w_empty;
    logic               w_push_req;
    logic               w_push;
    logic               w_pop;
    logic               w_drop_full;
    logic               w_drop_idle;
    logic               w_final;
    logic [512:0]       w_head;

    assign w_in_write  = (r_state == ST_WRITE);
    assign w_start     = start_operator && !w_in_write;
    assign w_full      = (r_count == (c_PTR_W+1)'(FIFO_DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_head      = r_mem[r_rd_ptr];

    assign wr_req_valid = w_in_write && !w_empty;
    assign wr_req_addr  = r_base + r_offset;
    // Payload is gated so idle/reset outputs read as zero instead of stale buffer contents.
    assign wr_req_data  = wr_req_valid ? w_head[512:1] : '0;
    assign wr_req_last  = wr_req_valid && w_head[0];

    assign w_pop       = wr_req_valid && wr_req_ready;
    assign w_push_req  = updated_centroid_valid && w_in_write;
    // A full buffer still accepts a line when the head leaves in the same cycle.
    assign w_push      = w_push_req && (!w_full || w_pop);
    assign w_drop_full = w_push_req && w_full && !w_pop;
    assign w_drop_idle = updated_centroid_valid && !w_in_write;
    assign w_final     = w_pop && wr_req_last && ((r_iter_cnt + 32'd1) == r_num_iter);

    assign iteration_done = r_iter_done;
    assign iteration_cnt  = r_iter_cnt;
    assign all_done       = r_all_done;
    assign overflow       = r_overflow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE:  if (start_operator) w_state_nx = ST_WRITE;
            ST_WRITE: if (w_final)        w_state_nx = ST_DONE;
            ST_DONE:  if (start_operator) w_state_nx = ST_WRITE;
            default:                      w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {updated_centroid, updated_centroid_last};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_base      <= '0;
            r_offset    <= '0;
            r_num_iter  <= '0;
            r_iter_cnt  <= '0;
            r_iter_done <= 1'b0;
            r_all_done  <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (w_start) begin
            // Leftover lines from a previous run are flushed so they never land in the new region.
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_base      <= centroid_base_addr;
            r_offset    <= '0;
            r_num_iter  <= (num_iteration == 32'd0) ? 32'd1 : num_iteration;
            r_iter_cnt  <= '0;
            r_iter_done <= 1'b0;
            r_all_done  <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                if (wr_req_last) begin
                    r_offset   <= '0;
                    r_iter_cnt <= r_iter_cnt + 32'd1;
                end else begin
                    r_offset   <= r_offset + 64'd1;
                end
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_iter_done <= w_pop && wr_req_last;
            r_all_done  <= r_all_done || (r_state == ST_DONE);
            r_overflow  <= r_overflow || w_drop_full;
        end
    end

`ifdef CENTROID_WR_DEBUG_EN
    logic [3:0][31:0] r_dbg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dbg <= '0;
        end else if (w_start) begin
            r_dbg <= '0;
        end else begin
            if (w_push)      r_dbg[0] <= r_dbg[0] + 32'd1;
            if (w_drop_full) r_dbg[1] <= r_dbg[1] + 32'd1;
            if (w_drop_idle) r_dbg[2] <= r_dbg[2] + 32'd1;
            if (w_pop)       r_dbg[3] <= r_dbg[3] + 32'd1;
        end
    end

    assign wr_debug_cnt = r_dbg;
`else
    logic w_unused;
    assign w_unused = w_drop_idle;
`endif

endmodule

`default_nettype wire

// File: tb/tb_centroid_wr_engine.sv
// tb_centroid_wr_engine: directed vectors with hand-computed expectations for centroid_wr_engine.
`default_nettype none

module tb_centroid_wr_engine;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_operator = 1'b0;
    logic [63:0]  centroid_base_addr = '0;
    logic [31:0]  num_iteration = '0;
    logic [511:0] updated_centroid = '0;
    logic         updated_centroid_valid = 1'b0;
    logic         updated_centroid_last = 1'b0;
    logic         wr_req_valid;
    logic         wr_req_ready = 1'b0;
    logic [63:0]  wr_req_addr;
    logic [511:0] wr_req_data;
    logic         wr_req_last;
    logic         iteration_done;
    logic [31:0]  iteration_cnt;
    logic         all_done;
    logic         overflow;

    int n_vec = 0;
    int n_err = 0;
    int n_done_pulses = 0;

    logic [63:0]  q_addr [$];
    logic [511:0] q_data [$];
    logic         q_last [$];

    logic         r_prev_stall = 1'b0;
    logic [63:0]  r_prev_addr;
    logic [511:0] r_prev_data;
    logic         r_prev_last;

    centroid_wr_engine #(.FIFO_DEPTH(64)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .start_operator         (start_operator),
        .centroid_base_addr     (centroid_base_addr),
        .num_iteration          (num_iteration),
        .updated_centroid       (updated_centroid),
        .updated_centroid_valid (updated_centroid_valid),
        .updated_centroid_last  (updated_centroid_last),
        .wr_req_valid           (wr_req_valid),
        .wr_req_ready           (wr_req_ready),
        .wr_req_addr            (wr_req_addr),
        .wr_req_data            (wr_req_data),
        .wr_req_last            (wr_req_last),
        .iteration_done         (iteration_done),
        .iteration_cnt          (iteration_cnt),
        .all_done               (all_done),
        .overflow               (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] pat(input int n);
        logic [31:0] a;
        logic [31:0] b;
        a = 32'hC0DE0000 + 32'(n);
        b = ~32'(n);
        return {8{a, b}};
    endfunction

    // Observation point is the falling edge, where inputs and DUT outputs are settled.
    always @(negedge clk) begin
        if (!rst_n) begin
            r_prev_stall <= 1'b0;
        end else begin
            if (r_prev_stall) begin
                chk("hold_valid", 512'(wr_req_valid), 512'(1));
                chk("hold_addr", 512'(wr_req_addr), 512'(r_prev_addr));
                chk("hold_data", wr_req_data, r_prev_data);
                chk("hold_last", 512'(wr_req_last), 512'(r_prev_last));
            end
            if (wr_req_valid && wr_req_ready) begin
                q_addr.push_back(wr_req_addr);
                q_data.push_back(wr_req_data);
                q_last.push_back(wr_req_last);
            end
            if (iteration_done) n_done_pulses++;
            r_prev_stall <= wr_req_valid && !wr_req_ready;
            r_prev_addr  <= wr_req_addr;
            r_prev_data  <= wr_req_data;
            r_prev_last  <= wr_req_last;
        end
    end

    task automatic clear_obs();
        q_addr.delete();
        q_data.delete();
        q_last.delete();
        n_done_pulses = 0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [63:0] base, input logic [31:0] niter);
        @(posedge clk); #1;
        start_operator     = 1'b1;
        centroid_base_addr = base;
        num_iteration      = niter;
        @(posedge clk); #1;
        start_operator     = 1'b0;
    endtask

    task automatic push_burst(input int first, input int cnt, input int last_at);
        for (int i = 0; i < cnt; i++) begin
            @(posedge clk); #1;
            updated_centroid_valid = 1'b1;
            updated_centroid       = pat(first + i);
            updated_centroid_last  = (i == last_at);
        end
        @(posedge clk); #1;
        updated_centroid_valid = 1'b0;
        updated_centroid_last  = 1'b0;
    endtask

    task automatic wait_beats(input string tag, input int k, input int budget);
        for (int i = 0; i < budget && q_addr.size() < k; i++) @(posedge clk);
        #1;
        chk(tag, 512'(q_addr.size()), 512'(k));
    endtask

    task automatic chk_beat(input string tag, input int idx, input logic [63:0] addr,
                            input int pid, input logic last);
        chk($sformatf("%s_addr%0d", tag, idx), 512'(q_addr[idx]), 512'(addr));
        chk($sformatf("%s_data%0d", tag, idx), q_data[idx], pat(pid));
        chk($sformatf("%s_last%0d", tag, idx), 512'(q_last[idx]), 512'(last));
    endtask

    initial begin
        // Reset state
        cycles(3);
        chk("rst_valid", 512'(wr_req_valid), 512'(0));
        chk("rst_addr", 512'(wr_req_addr), 512'(0));
        chk("rst_data", wr_req_data, 512'(0));
        chk("rst_last", 512'(wr_req_last), 512'(0));
        chk("rst_idone", 512'(iteration_done), 512'(0));
        chk("rst_cnt", 512'(iteration_cnt), 512'(0));
        chk("rst_alldone", 512'(all_done), 512'(0));
        chk("rst_ovf", 512'(overflow), 512'(0));
        rst_n = 1'b1;
        cycles(2);

        // One iteration, three lines
        clear_obs();
        wr_req_ready = 1'b1;
        do_start(64'h1000, 32'd1);
        push_burst(0, 3, 2);
        wait_beats("t1_beats", 3, 20);
        for (int i = 0; i < 3; i++) chk_beat("t1", i, 64'h1000 + 64'(i), i, i == 2);
        cycles(3);
        chk("t1_cnt", 512'(iteration_cnt), 512'(1));
        chk("t1_pulses", 512'(n_done_pulses), 512'(1));
        chk("t1_alldone", 512'(all_done), 512'(1));
        chk("t1_ovf", 512'(overflow), 512'(0));

        // Two iterations, two lines each
        clear_obs();
        do_start(64'h1000, 32'd2);
        chk("t2_alldone_clr", 512'(all_done), 512'(0));
        chk("t2_cnt_clr", 512'(iteration_cnt), 512'(0));
        push_burst(10, 2, 1);
        wait_beats("t2_beats_a", 2, 20);
        cycles(3);
        chk("t2_cnt_mid", 512'(iteration_cnt), 512'(1));
        chk("t2_alldone_mid", 512'(all_done), 512'(0));
        push_burst(20, 2, 1);
        wait_beats("t2_beats_b", 4, 20);
        chk_beat("t2", 0, 64'h1000, 10, 1'b0);
        chk_beat("t2", 1, 64'h1001, 11, 1'b1);
        chk_beat("t2", 2, 64'h1000, 20, 1'b0);
        chk_beat("t2", 3, 64'h1001, 21, 1'b1);
        cycles(3);
        chk("t2_cnt", 512'(iteration_cnt), 512'(2));
        chk("t2_pulses", 512'(n_done_pulses), 512'(2));
        chk("t2_alldone", 512'(all_done), 512'(1));

        // Overflow: 65 lines into a 64-deep buffer with the sink stalled
        clear_obs();
        wr_req_ready = 1'b0;
        do_start(64'h2000, 32'd1);
        push_burst(100, 65, 63);
        cycles(1);
        chk("t3_ovf", 512'(overflow), 512'(1));
        chk("t3_valid", 512'(wr_req_valid), 512'(1));
        chk("t3_addr0", 512'(wr_req_addr), 512'(64'h2000));
        wr_req_ready = 1'b1;
        wait_beats("t3_beats", 64, 200);
        for (int i = 0; i < 64; i++) chk_beat("t3", i, 64'h2000 + 64'(i), 100 + i, i == 63);
        cycles(5);
        chk("t3_nomore", 512'(q_addr.size()), 512'(64));
        chk("t3_alldone", 512'(all_done), 512'(1));

        // Ready toggling every cycle while lines stream in
        clear_obs();
        wr_req_ready = 1'b0;
        do_start(64'h3000, 32'd1);
        fork
            push_burst(200, 6, 5);
            for (int i = 0; i < 30; i++) begin
                @(posedge clk); #1;
                wr_req_ready = ~wr_req_ready;
            end
        join
        wait_beats("t4_beats", 6, 40);
        for (int i = 0; i < 6; i++) chk_beat("t4", i, 64'h3000 + 64'(i), 200 + i, i == 5);
        cycles(5);
        chk("t4_nomore", 512'(q_addr.size()), 512'(6));
        chk("t4_alldone", 512'(all_done), 512'(1));

        // Reset with buffered lines
        clear_obs();
        wr_req_ready = 1'b0;
        do_start(64'h4000, 32'd1);
        push_burst(300, 5, 99);
        cycles(1);
        chk("t5_pre_valid", 512'(wr_req_valid), 512'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_valid_async", 512'(wr_req_valid), 512'(0));
        chk("t5_addr_async", 512'(wr_req_addr), 512'(0));
        cycles(2);
        rst_n = 1'b1;
        wr_req_ready = 1'b1;
        cycles(10);
        chk("t5_nobeats", 512'(q_addr.size()), 512'(0));
        chk("t5_valid", 512'(wr_req_valid), 512'(0));
        chk("t5_cnt", 512'(iteration_cnt), 512'(0));

        // Lines offered while idle are dropped silently
        clear_obs();
        push_burst(400, 3, 2);
        do_start(64'h5000, 32'd1);
        cycles(5);
        chk("t6_nobeats", 512'(q_addr.size()), 512'(0));
        chk("t6_ovf", 512'(overflow), 512'(0));
        chk("t6_valid", 512'(wr_req_valid), 512'(0));
        push_burst(500, 1, 0);
        wait_beats("t6_beats", 1, 20);
        chk_beat("t6", 0, 64'h5000, 500, 1'b1);
        cycles(3);
        chk("t6_alldone", 512'(all_done), 512'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/centroid_wr_engine.md
CENTROID_WR_ENGINE -- requirements
Module: centroid_wr_engine

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 64, cacheline buffer depth (power of 2, >=4).
REQ-002 SHALL have port clk  input  1  sole clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start_operator  input  1  one-cycle pulse; latches configuration.
REQ-005 SHALL have port centroid_base_addr  input  64  cacheline address of centroid region.
REQ-006 SHALL have port num_iteration  input  32  k-means iterations to write back.
REQ-007 SHALL have port updated_centroid  input  512  updated centroid cacheline.
REQ-008 SHALL have port updated_centroid_valid  input  1  cacheline qualifier; no backpressure.
REQ-009 SHALL have port updated_centroid_last  input  1  final cacheline of one iteration.
REQ-010 SHALL have ports wr_req_valid out 1, wr_req_ready in 1, wr_req_addr out 64, wr_req_data out 512, wr_req_last out 1 as the write-engine request channel.
REQ-011 SHALL have port iteration_done  output  1  one-cycle pulse per completed iteration.
REQ-012 SHALL have port iteration_cnt  output  32  completed iterations.
REQ-013 SHALL have port all_done  output  1  level; all iterations written.
REQ-014 SHALL have port overflow  output  1  sticky; a cacheline was dropped on full FIFO.

Function
REQ-015 SHALL implement FSM IDLE, WRITE, DONE; IDLE->WRITE on start_operator; WRITE->DONE on accepted last beat of final iteration; DONE->WRITE on start_operator.
REQ-016 SHALL on start_operator latch centroid_base_addr and num_iteration (0 treated as 1), clear iteration_cnt, address offset, all_done and overflow.
REQ-017 SHALL ignore start_operator while in WRITE.
REQ-018 SHALL push {updated_centroid, updated_centroid_last} into the FIFO when updated_centroid_valid and state is WRITE.
REQ-019 SHALL drop input valid in IDLE or DONE without setting overflow.
REQ-020 SHALL on push into a full FIFO without simultaneous pop drop the cacheline and set overflow; push with simultaneous pop when full SHALL be accepted.
REQ-021 SHALL drive wr_req_valid whenever FIFO non-empty and state is WRITE; first beat no earlier than 1 cycle after push.
REQ-022 SHALL hold wr_req_addr/data/last stable while wr_req_valid and not wr_req_ready.
REQ-023 SHALL pop one entry per cycle with wr_req_valid and wr_req_ready.
REQ-024 SHALL drive wr_req_addr = base + offset, offset counting accepted beats, 64-bit wrap.
REQ-025 SHALL on accepted beat with wr_req_last reset offset to 0, increment iteration_cnt, pulse iteration_done the next cycle.
REQ-026 SHALL set all_done the cycle after iteration_cnt reaches latched num_iteration, holding until next start_operator.
REQ-027 SHALL ignore beats after a last flag in the same cycle only by counting, never by merging iterations.

Reset
REQ-028 SHALL on rst_n low asynchronously enter IDLE, empty FIFO, zero wr_req_valid, wr_req_last, iteration_done, all_done, overflow, iteration_cnt, offset; wr_req_addr/data 0.
REQ-029 SHALL on reset mid-WRITE discard buffered and in-flight cachelines; no request reissued after release.

Configuration
REQ-030 SHALL with macro CENTROID_WR_DEBUG_EN defined add output wr_debug_cnt [3:0][32] counting pushes, drops-on-full, drops-while-idle, accepted beats, cleared by reset and start_operator.
REQ-031 SHALL without CENTROID_WR_DEBUG_EN omit that port and counters; other behaviour identical.

Verification
REQ-032 SHALL test: base 0x1000, num_iteration 1, 3 cachelines (last on 3rd), ready=1 -> addrs 0x1000,0x1001,0x1002, wr_req_last on 3rd, iteration_done pulse, all_done=1.
REQ-033 SHALL test: num_iteration 2, 2 lines each -> addrs 0x1000,0x1001 twice; iteration_cnt 2; all_done after 4th beat only.
REQ-034 SHALL test: ready=0, 65 pushes at FIFO_DEPTH 64 -> 64 stored, overflow=1; release ready -> 64 beats in order.
REQ-035 SHALL test: ready toggling every cycle -> payload stable while stalled, no beat lost or duplicated.
REQ-036 SHALL test: rst_n low with 5 buffered lines -> wr_req_valid 0 immediately, FIFO empty, no beats after release.
REQ-037 SHALL test: valid inputs in IDLE then start_operator -> none written, overflow stays 0.
